// File: rtl/operand_loader_pkg.sv
// Shared types and helpers for the operand loader.
// Optional build macro used by this block: LOAD_EDGE_DETECT_EN.
package operand_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        LAUNCH,
        WAIT_READY,
        FLUSH
    } state_e;

    // Index width that stays at least one bit even for a single operand.
    function automatic int min_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/operand_loader_fsm.sv
// Transaction sequencer: state, operand index, Load qualification and output decode.
// Define LOAD_EDGE_DETECT_EN to qualify Load on its rising edge instead of its level.
module operand_loader_fsm
    import operand_loader_pkg::*;
#(
    parameter int NUM_OPERANDS = 2,
    parameter int IDX_W        = min_width(NUM_OPERANDS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    load,
    input  logic                    ready,
    output logic [NUM_OPERANDS-1:0] load_ch,
    output logic [IDX_W-1:0]        load_idx,
    output logic                    busy,
    output logic                    flag_flush,
    output logic                    launch,
    output logic                    capture
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OPERANDS - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             load_qual;

`ifdef LOAD_EDGE_DETECT_EN
    logic load_prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) load_prev_q <= 1'b0;
        else       load_prev_q <= load;
    end

    // A held Load produces one capture; it must drop before the next one.
    assign load_qual = load & ~load_prev_q;
`else
    assign load_qual = load;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    idx_d   = '0;
                end
            end
            LOAD: begin
                if (load_qual) begin
                    capture = 1'b1;
                    if (idx_q == LAST_IDX) state_d = LAUNCH;
                    else                   idx_d   = idx_q + IDX_W'(1);
                end
            end
            LAUNCH:     state_d = WAIT_READY;
            WAIT_READY: if (ready) state_d = FLUSH;
            FLUSH:      state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    assign load_ch    = (state_q == LOAD) ? (NUM_OPERANDS'(1) << idx_q) : '0;
    assign load_idx   = (state_q == LOAD) ? idx_q : '0;
    assign busy       = (state_q != IDLE);
    assign flag_flush = (state_q == FLUSH);
    assign launch     = (state_q == LAUNCH);

endmodule

// File: rtl/operand_loader.sv
// Operand-capture front end for the MDR core: N operand registers plus the start pulse.
// Build option LOAD_EDGE_DETECT_EN selects edge-qualified Load (see operand_loader_fsm).
module operand_loader
    import operand_loader_pkg::*;
#(
    parameter int WORD_LENGTH  = 16,
    parameter int NUM_OPERANDS = 2,
    parameter int IDX_W        = min_width(NUM_OPERANDS)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                Start,
    input  logic                                Load,
    input  logic [WORD_LENGTH-1:0]              Data,
    input  logic                                Ready,
    output logic [NUM_OPERANDS-1:0]             Load_ch,
    output logic [IDX_W-1:0]                    load_idx,
    output logic [NUM_OPERANDS*WORD_LENGTH-1:0] Operands,
    output logic                                flagStart,
    output logic                                flagFlush,
    output logic                                busy
);

    logic [NUM_OPERANDS*WORD_LENGTH-1:0] operands_q, operands_d;
    logic                                flag_start_q, flag_start_d;
    logic                                launch;
    logic                                capture;

    operand_loader_fsm #(
        .NUM_OPERANDS (NUM_OPERANDS),
        .IDX_W        (IDX_W)
    ) u_fsm (
        .clk        (clk),
        .reset      (reset),
        .start      (Start),
        .load       (Load),
        .ready      (Ready),
        .load_ch    (Load_ch),
        .load_idx   (load_idx),
        .busy       (busy),
        .flag_flush (flagFlush),
        .launch     (launch),
        .capture    (capture)
    );

    always_comb begin
        operands_d = operands_q;
        if (capture) operands_d[int'(load_idx)*WORD_LENGTH +: WORD_LENGTH] = Data;
    end

    // Registering the LAUNCH decode puts flagStart in the first WAIT_READY cycle.
    assign flag_start_d = launch;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            operands_q   <= '0;
            flag_start_q <= 1'b0;
        end else begin
            operands_q   <= operands_d;
            flag_start_q <= flag_start_d;
        end
    end

    assign Operands  = operands_q;
    assign flagStart = flag_start_q;

endmodule

// File: doc/operand_loader.md
# operand_loader

Parametrised operand-capture front end for the multiply/divide/root (MDR) datapath. After a Start request it collects NUM_OPERANDS words from a shared Data bus, one per Load event, into dedicated operand registers. It then issues a single registered start pulse to the MDR core, waits for Ready, and emits a one-cycle flush. It generalises the fixed two-channel X/Y loader to N channels and adds a busy indication and an operand index.

## Interface
- WORD_LENGTH, 16, width of each operand word
- NUM_OPERANDS, 2, number of operands captured per transaction (≥1)
- IDX_W, $clog2(NUM_OPERANDS) (minimum 1), width of the operand index
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- Start  input  1  begin transaction (sampled in IDLE only)
- Load  input  1  load request; captures Data into the current operand
- Data  input  WORD_LENGTH  shared operand data bus
- Ready  input  1  MDR core finished (sampled in WAIT_READY only)
- Load_ch  output  NUM_OPERANDS  one-hot; bit i high while operand i is awaited
- load_idx  output  IDX_W  index of the operand currently awaited; 0 outside LOAD
- Operands  output  NUM_OPERANDS*WORD_LENGTH  packed operand registers, operand i at [i*WORD_LENGTH +: WORD_LENGTH]
- flagStart  output  1  one-cycle start pulse to MDR core
- flagFlush  output  1  one-cycle flush pulse after Ready
- busy  output  1  high in every state except IDLE

## Operation
- States: IDLE, LOAD, LAUNCH, WAIT_READY, FLUSH.
- IDLE: Start=1 -> LOAD, idx←0. Load is ignored in IDLE, including when Start and Load are high in the same cycle; operand 0 is not captured.
- LOAD: a qualified Load writes Data into operand idx on that edge. If idx==NUM_OPERANDS-1 -> LAUNCH; otherwise idx←idx+1.
- LAUNCH: one cycle, unconditional -> WAIT_READY. The internal start request is high here.
- WAIT_READY: Ready=1 -> FLUSH; otherwise hold.
- FLUSH: one cycle, flagFlush=1, -> IDLE.
- Start outside IDLE is ignored. Ready outside WAIT_READY is ignored.
- Operand registers change only on a qualified Load in LOAD. They hold their values across FLUSH and IDLE until overwritten.
- Load_ch = one-hot(idx) in LOAD, and all zeros in every other state.
- Reset at any point, including mid-load: state→IDLE, idx→0, all operands→0. Every output is 0 after reset.

## Timing
- State, idx and operands are registered. Load_ch, load_idx, busy and flagFlush decode combinationally from state.
- flagStart is the LAUNCH request passed through a 1-bit register. It is high exactly one cycle, in the first WAIT_READY cycle, one cycle after LAUNCH.
- Latency: last capture edge -> LAUNCH (1 cycle) -> flagStart (2nd cycle after the capture edge).
- A Ready present during the flagStart cycle is accepted: FLUSH follows in the next cycle.
- Minimum transaction: Start edge plus NUM_OPERANDS Load edges, then LAUNCH, WAIT_READY and FLUSH, giving NUM_OPERANDS+4 cycles from Start to return to IDLE.

## Configuration
- LOAD_EDGE_DETECT_EN defined: Load is qualified on its rising edge via a registered copy of Load (reset to 0). A Load held high for many cycles captures exactly one operand, and a new capture needs Load to go low and then high again. The rising edge is detected as Load=1 with the previous-cycle Load=0, so the first qualified capture happens in the same cycle Load rises.
- Not defined: Load is level-qualified. Every LOAD cycle with Load=1 captures one operand and advances idx, so a held Load fills consecutive operands on consecutive cycles.

## Structure
- Package operand_loader_pkg: state enum type (IDLE, LOAD, LAUNCH, WAIT_READY, FLUSH) and the minimum-width helper used to compute IDX_W.
- Sub-module operand_loader_fsm: state register, idx counter, Load qualification and output decode. The top level holds the operand register array and the flagStart register.

## Test plan
- NUM_OPERANDS=2: Start, then Load with Data=16'h1234, then Load with Data=16'h00FF -> Operands={16'h00FF,16'h1234}. Load_ch is 01 then 10. flagStart pulses exactly one cycle, two cycles after the second capture edge.
- In WAIT_READY, hold Ready=0 for 10 cycles, then pulse it -> flagStart stays low and busy stays high throughout. flagFlush pulses one cycle, then busy drops.
- Start and Load high together in IDLE with Data=16'hAAAA -> operand 0 not written, Load_ch=01 next cycle.
- Assert reset after the first capture -> all outputs 0 at once. Operands cleared, state is IDLE, and a fresh transaction completes normally.
- Load held high for 5 cycles in LOAD with NUM_OPERANDS=3: with LOAD_EDGE_DETECT_EN exactly one capture and load_idx=1; without it, three captures, then LAUNCH.
- Start and Ready pulses during LOAD and Ready during LAUNCH -> no state change and no flagStart or flagFlush.
